// File: rtl/decay_sweep_scheduler.sv
// decay_sweep_scheduler: runs the shared potential_decay datapath over every
// neuron once per timestep tick, after a one-time potential-memory init pass.
module decay_sweep_scheduler #(
  parameter int          NUM_NEURONS     = 30,
  parameter int          ADDR_W          = 5,
  parameter int          SETTLE_CYCLES   = 4,
  parameter int          TIMESTEP_CYCLES = 256,
  parameter logic [31:0] INIT_POTENTIAL  = 32'h41DED852
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              enable,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [3:0]        cfg_rate,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data,
  output logic [31:0]       new_potential,
  output logic [3:0]        decay_rate,
  output logic              clear_decay,
  input  logic [31:0]       decayed_potential,
  output logic              busy,
  output logic              sweep_done,
  output logic [15:0]       timestep_count,
  output logic              overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_NEURONS - 1);
  localparam logic [ADDR_W:0]   NUM_N       = (ADDR_W + 1)'(NUM_NEURONS);
  localparam int                SW          = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]     SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam int                TW          = $clog2(TIMESTEP_CYCLES + 1);
  localparam logic [TW-1:0]     TICK_VAL    = TW'(TIMESTEP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, INIT, WAIT_TICK, READ, LOAD, CLEAR, WRITE, NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              init_done_q, init_done_d;
  logic [TW-1:0]     ts_q;
  logic [31:0]       new_potential_q;
  logic [3:0]        decay_rate_q;
  logic [31:0]       captured_q;
  logic [15:0]       count_q;
  logic              overrun_q;
  logic [3:0]        rate_q [NUM_NEURONS];

  logic tick;
  logic last_addr;

  assign tick      = init_done_q && enable && (ts_q == TICK_VAL);
  assign last_addr = (addr_q == LAST_ADDR);

  // Per-neuron decay-rate table; writes land in any state, range-checked.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      for (int i = 0; i < NUM_NEURONS; i++) rate_q[i] <= 4'b0001;
    end else if (cfg_we && ({1'b0, cfg_addr} < NUM_N)) begin
      rate_q[cfg_addr] <= cfg_rate;
    end
  end

  // Free-running timestep counter, held at 0 until init is done and enabled.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      ts_q <= '0;
    end else if (!enable || !init_done_q || tick) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end

  // State, address and settle-counter registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      settle_q    <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      settle_q    <= settle_d;
      init_done_q <= init_done_d;
    end
  end

  // Sequencing: init pass once, then one neuron at a time on every tick.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    settle_d    = settle_q;
    init_done_d = init_done_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          addr_d  = '0;
          state_d = init_done_q ? WAIT_TICK : INIT;
        end
      end
      INIT: begin
        if (last_addr) begin
          init_done_d = 1'b1;
          addr_d      = '0;
          state_d     = WAIT_TICK;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      WAIT_TICK: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (tick) begin
          addr_d  = '0;
          state_d = READ;
        end
      end
      READ: state_d = LOAD;
      LOAD: begin
        settle_d = '0;
        state_d  = CLEAR;
      end
      CLEAR: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = WRITE;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      WRITE: state_d = NEXT;
      NEXT: begin
        if (last_addr) begin
          addr_d  = '0;
          state_d = enable ? WAIT_TICK : IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch in LOAD, result capture on the last settle cycle, counters.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      new_potential_q <= '0;
      decay_rate_q    <= '0;
      captured_q      <= '0;
      count_q         <= '0;
      overrun_q       <= 1'b0;
    end else begin
      if (state_q == LOAD) begin
        new_potential_q <= mem_rd_data;
        decay_rate_q    <= rate_q[addr_q];
      end
      if (state_q == CLEAR && settle_q == SETTLE_LAST) begin
        captured_q <= decayed_potential;
      end
      if (state_q == NEXT && last_addr) begin
        count_q <= count_q + 16'd1;
      end
      if (tick && state_q != WAIT_TICK) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Write data: init constant during INIT, captured result during WRITE.
  always_comb begin
    mem_wr_data = '0;
    if (state_q == INIT) begin
      mem_wr_data = INIT_POTENTIAL;
    end else if (state_q == WRITE) begin
      mem_wr_data = captured_q;
    end
  end

  assign mem_addr       = addr_q;
  assign mem_rd_en      = (state_q == READ);
  assign mem_wr_en      = (state_q == INIT) || (state_q == WRITE);
  assign new_potential  = new_potential_q;
  assign decay_rate     = decay_rate_q;
  assign clear_decay    = (state_q == CLEAR);
  assign sweep_done     = (state_q == NEXT) && last_addr;
  assign busy           = (state_q == INIT) || (state_q == READ) || (state_q == LOAD) ||
                          (state_q == CLEAR) || (state_q == WRITE) ||
                          ((state_q == NEXT) && !last_addr);
  assign timestep_count = count_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_decay_sweep_scheduler.sv
// Bench for decay_sweep_scheduler: default instance for sweep behaviour and a
// short-timestep instance whose ticks land inside a sweep.
module tb_decay_sweep_scheduler;

  localparam logic [31:0] INIT_VAL  = 32'h41DED852;
  localparam logic [31:0] EIGHT     = 32'h41000000;
  localparam logic [31:0] GARBAGE   = 32'hDEADBEEF;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [3:0]  rate;
    logic [31:0] expMem;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        enable = 1'b0;
  logic        cfgWe = 1'b0;
  logic [4:0]  cfgAddr = '0;
  logic [3:0]  cfgRate = '0;
  logic        preload = 1'b0;

  logic [4:0]  memAddr1, memAddr2;
  logic        memRdEn1, memRdEn2, memWrEn1, memWrEn2;
  logic [31:0] memRdData1 = '0, memRdData2 = '0;
  logic [31:0] memWrData1, memWrData2, newPot1, newPot2, decayed1, decayed2;
  logic [3:0]  rate1, rate2;
  logic        clear1, clear2, busy1, busy2, done1, done2, overrun1, overrun2;
  logic [15:0] tsCount1, tsCount2;
  logic        anyOut1, anyOut2;

  logic [31:0] mem1 [32];
  logic [31:0] mem2 [32];
  int          clrCnt1 = 0, clrCnt2 = 0;

  int          pulses1 = 0, badLen1 = 0, npMoves1 = 0, overlap1 = 0;
  int          writes1 = 0, reads1 = 0, curLen1 = 0;
  logic [31:0] npAtRise1 = '0;
  logic        prevClear1 = 1'b0;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  decay_sweep_scheduler dut1 (
    .CLK(CLK), .RESETN(RESETN), .enable(enable),
    .cfg_we(cfgWe), .cfg_addr(cfgAddr), .cfg_rate(cfgRate),
    .mem_addr(memAddr1), .mem_rd_en(memRdEn1), .mem_rd_data(memRdData1),
    .mem_wr_en(memWrEn1), .mem_wr_data(memWrData1),
    .new_potential(newPot1), .decay_rate(rate1), .clear_decay(clear1),
    .decayed_potential(decayed1), .busy(busy1), .sweep_done(done1),
    .timestep_count(tsCount1), .overrun(overrun1)
  );

  decay_sweep_scheduler #(.TIMESTEP_CYCLES(100)) dut2 (
    .CLK(CLK), .RESETN(RESETN), .enable(enable),
    .cfg_we(cfgWe), .cfg_addr(cfgAddr), .cfg_rate(cfgRate),
    .mem_addr(memAddr2), .mem_rd_en(memRdEn2), .mem_rd_data(memRdData2),
    .mem_wr_en(memWrEn2), .mem_wr_data(memWrData2),
    .new_potential(newPot2), .decay_rate(rate2), .clear_decay(clear2),
    .decayed_potential(decayed2), .busy(busy2), .sweep_done(done2),
    .timestep_count(tsCount2), .overrun(overrun2)
  );

  always #5 CLK = ~CLK;

  // Stand-in decay unit: each rate code divides by a power of two.
  function automatic logic [31:0] decayModel(input logic [31:0] v, input logic [3:0] r);
    logic [7:0] sh;
    case (r)
      4'b0010: sh = 8'd1;
      4'b0100: sh = 8'd2;
      4'b1000: sh = 8'd3;
      4'b0011: sh = 8'd4;
      default: sh = 8'd0;
    endcase
    return {v[31], v[30:23] - sh, v[22:0]};
  endfunction

  // Result is only valid in the fourth consecutive cycle of clear_decay.
  assign decayed1 = (clear1 && clrCnt1 == 3) ? decayModel(newPot1, rate1) : GARBAGE;
  assign decayed2 = (clear2 && clrCnt2 == 3) ? decayModel(newPot2, rate2) : GARBAGE;

  assign anyOut1 = |{memAddr1, memRdEn1, memWrEn1, memWrData1, newPot1, rate1,
                     clear1, busy1, done1, tsCount1, overrun1};
  assign anyOut2 = |{memAddr2, memRdEn2, memWrEn2, memWrData2, newPot2, rate2,
                     clear2, busy2, done2, tsCount2, overrun2};

  // Counts how long clear_decay has been held, for the settle model.
  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      clrCnt1 <= 0;
      clrCnt2 <= 0;
    end else begin
      clrCnt1 <= clear1 ? clrCnt1 + 1 : 0;
      clrCnt2 <= clear2 ? clrCnt2 + 1 : 0;
    end
  end

  // Potential memories with one-cycle read latency and a bulk preload.
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) begin
        mem1[i] <= EIGHT;
        mem2[i] <= EIGHT;
      end
    end else begin
      if (memWrEn1) mem1[memAddr1] <= memWrData1;
      if (memWrEn2) mem2[memAddr2] <= memWrData2;
    end
    if (memRdEn1) memRdData1 <= mem1[memAddr1];
    if (memRdEn2) memRdData2 <= mem2[memAddr2];
  end

  // Handshake monitor: pulse count and length, operand stability, port overlap.
  always @(posedge CLK) begin
    if (memRdEn1 && memWrEn1) overlap1 <= overlap1 + 1;
    if (memWrEn1) writes1 <= writes1 + 1;
    if (memRdEn1) reads1 <= reads1 + 1;
    if (clear1) begin
      if (!prevClear1) begin
        pulses1   <= pulses1 + 1;
        npAtRise1 <= newPot1;
        curLen1   <= 1;
      end else begin
        curLen1 <= curLen1 + 1;
        if (newPot1 != npAtRise1) npMoves1 <= npMoves1 + 1;
      end
    end else if (prevClear1 && curLen1 != 4) begin
      badLen1 <= badLen1 + 1;
    end
    prevClear1 <= clear1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] a, input logic [3:0] r);
    cfgWe   = we;
    cfgAddr = a;
    cfgRate = r;
    stepCycle();
    cfgWe   = 1'b0;
  endtask

  task automatic waitDone1(input int budget, output bit seen);
    int n;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      stepCycle();
      n++;
      if (done1) seen = 1'b1;
    end
  endtask

  // Called on the first INIT cycle; leaves the bench on the first WAIT_TICK cycle.
  task automatic checkInit(input string tag);
    int good;
    good = 0;
    for (int i = 0; i < 30; i++) begin
      if (memWrEn1 && busy1 && memWrData1 == INIT_VAL && memAddr1 == 5'(i) && !memRdEn1)
        good++;
      stepCycle();
    end
    checkOutput({tag, "_writes"}, 64'(good), 64'd30);
    checkOutput({tag, "_busy_after"}, 64'(busy1), 64'd0);
    checkOutput({tag, "_wr_after"}, 64'(memWrEn1), 64'd0);
  endtask

  initial begin
    vec_t        vecs [8];
    int          cyc0, p0, b0, n0, w0, r0;
    bit          seen;
    logic [31:0] before12;

    vecs[0] = '{1'b1, 5'd5,  4'b0100, 32'h40000000};
    vecs[1] = '{1'b1, 5'd0,  4'b0010, 32'h40800000};
    vecs[2] = '{1'b1, 5'd29, 4'b1000, 32'h3F800000};
    vecs[3] = '{1'b1, 5'd10, 4'b0011, 32'h3F000000};
    vecs[4] = '{1'b1, 5'd7,  4'b0100, EIGHT};
    vecs[5] = '{1'b1, 5'd7,  4'b0001, EIGHT};
    vecs[6] = '{1'b0, 5'd12, 4'b0100, EIGHT};
    vecs[7] = '{1'b0, 5'd1,  4'b1000, EIGHT};

    RESETN = 1'b0;
    repeat (3) stepCycle();
    checkOutput("reset_outputs", 64'(anyOut1), 64'd0);
    checkOutput("reset_outputs_short", 64'(anyOut2), 64'd0);

    RESETN = 1'b1;
    stepCycle();
    checkOutput("idle_busy", 64'(busy1), 64'd0);

    enable = 1'b1;
    stepCycle();
    checkInit("init");
    cyc0 = cyc;

    preload = 1'b1;
    stepCycle();
    preload = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].rate);

    p0 = pulses1;
    b0 = badLen1;
    n0 = npMoves1;
    waitDone1(600, seen);
    checkOutput("sweep1_seen", 64'(seen), 64'd1);
    // tick when the counter hits 255, then 30 neurons x 8 cycles, last NEXT at 495
    checkOutput("sweep1_latency", 64'(cyc - cyc0), 64'd495);
    checkOutput("sweep1_last_addr", 64'(memAddr1), 64'd29);
    checkOutput("sweep1_busy_at_done", 64'(busy1), 64'd0);
    stepCycle();
    checkOutput("sweep1_done_pulse", 64'(done1), 64'd0);
    checkOutput("sweep1_count", 64'(tsCount1), 64'd1);
    checkOutput("clear_pulses", 64'(pulses1 - p0), 64'd30);
    checkOutput("clear_pulse_len", 64'(badLen1 - b0), 64'd0);
    checkOutput("operand_stable", 64'(npMoves1 - n0), 64'd0);
    checkOutput("no_overrun", 64'(overrun1), 64'd0);
    checkOutput("short_overrun", 64'(overrun2), 64'd1);
    checkOutput("short_count", 64'(tsCount2), 64'd1);

    for (int i = 0; i < 8; i++)
      checkOutput($sformatf("table_mem%0d", vecs[i].addr), 64'(mem1[vecs[i].addr]),
                  64'(vecs[i].expMem));

    while ((cyc - cyc0) < 600) stepCycle();
    checkOutput("sweep2_active", 64'(busy1), 64'd1);
    enable = 1'b0;
    waitDone1(300, seen);
    checkOutput("sweep2_seen", 64'(seen), 64'd1);
    checkOutput("sweep2_last_addr", 64'(memAddr1), 64'd29);
    stepCycle();
    checkOutput("sweep2_count", 64'(tsCount1), 64'd2);
    checkOutput("sweep2_mem5", 64'(mem1[5]), 64'h3F000000);
    checkOutput("sweep2_mem0", 64'(mem1[0]), 64'h40000000);
    checkOutput("short_count2", 64'(tsCount2), 64'd2);

    w0 = writes1;
    r0 = reads1;
    repeat (600) stepCycle();
    checkOutput("idle_writes", 64'(writes1 - w0), 64'd0);
    checkOutput("idle_reads", 64'(reads1 - r0), 64'd0);
    checkOutput("idle_busy2", 64'(busy1), 64'd0);
    checkOutput("idle_count", 64'(tsCount1), 64'd2);

    enable = 1'b1;
    w0 = writes1;
    repeat (250) stepCycle();
    checkOutput("reenable_no_init", 64'(writes1 - w0), 64'd0);
    checkOutput("reenable_busy", 64'(busy1), 64'd0);
    waitDone1(400, seen);
    checkOutput("sweep3_seen", 64'(seen), 64'd1);
    stepCycle();
    checkOutput("sweep3_count", 64'(tsCount1), 64'd3);

    seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      stepCycle();
      if (clear1 && memAddr1 == 5'd12) seen = 1'b1;
    end
    checkOutput("reach_n12_clear", 64'(seen), 64'd1);
    before12 = mem1[12];
    #2;
    RESETN = 1'b0;
    #1;
    checkOutput("abort_outputs", 64'(anyOut1), 64'd0);
    w0 = writes1;
    repeat (3) stepCycle();
    checkOutput("abort_writes", 64'(writes1 - w0), 64'd0);
    checkOutput("abort_mem12", 64'(mem1[12]), 64'(before12));
    RESETN = 1'b1;
    stepCycle();
    checkInit("reinit");
    checkOutput("reinit_count", 64'(tsCount1), 64'd0);

    checkOutput("rd_wr_overlap", 64'(overlap1), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
